jtag_mac_host: RTL and testbench
================================

Name: jtag_mac_host

Overview:
- Host-side initiator for the chif JTAG framing protocol.
- Accepts write, read, version and reset commands on a valid/ready request port and serializes each as an LSB-first bitstream on `tdi`/`sel` with a per-bit strobe `tck_en`.
- Captures `tdo` readback into a byte stream.
- Used as the loopback driver for the FPGA-side MAC in simulation and as the front end of the on-board host bridge. The downstream `tck` is `chif_clk` gated by `tck_en`.

Parameters:
- SYNC_BYTE, 8'hD7, frame sync pattern, sent LSB first.
- RST_GAP, 128, `tck_en` cycles of `sel`=0 idle after a reset frame; must be >100.
- RD_OFS, 0, extra zero bits shifted between the skip byte and the first sampled readback bit.

Ports:
- chif_clk  in  1  single clock; one bit per cycle when `tck_en`=1.
- sys_rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 write, 01 read, 10 version, 11 reset.
- cmd_len  in  13  write byte count, or max read byte count.
- cmd_simcycle  in  16  simcycle field for write frames.
- wr_data  in  8  write payload byte.
- wr_valid  in  1  payload byte valid.
- wr_ready  out  1  byte consumed this cycle.
- rd_data  out  8  received byte.
- rd_valid  out  1  one-cycle pulse per received byte; no backpressure.
- ver_data  out  32  last version word captured.
- rd_count  out  13  length word returned by the target.
- done  out  1  one-cycle pulse at frame end.
- err  out  1  qualifies `done`; returned length exceeded `cmd_len`.
- busy  out  1  high outside IDLE.
- tck_en  out  1  bit strobe; target `tck` edge occurs only when high.
- tdi  out  1  serial data to target.
- sel  out  1  target select; high during every `tck_en` bit of a frame.
- tdo  in  1  serial data from target, sampled at the posedge where `tck_en`=1.

Behaviour:
- **Reset:** `sys_rst` forces IDLE. All outputs go to 0 except `cmd_ready`=1. `rd_data`, `ver_data` and `rd_count` are also cleared. Reset mid-frame aborts immediately; no `done` is issued.
- **Handshake:** A command is accepted on `cmd_valid`&&`cmd_ready`. `cmd_len` and `cmd_simcycle` are latched. The first frame bit appears the next cycle.
- **Bit order:** All fields are sent LSB first, one bit per `tck_en` cycle.
- **States:** IDLE, SYNC(8), CMD(8), LEN(16), SIM(16), WDAT, SKIP(8), PAD(RD_OFS), RLEN(16), RDAT, VDAT(32), RGAP.
- **Command byte values:** 0x00 write, 0x01 read, 0x05 version, 0x07 reset. Only bits [2:0] are significant; the rest are sent as 0.
- **Write frame:** SYNC, CMD, LEN = {3'b0, `cmd_len`}, SIM = `cmd_simcycle`, then WDAT for `cmd_len` bytes, then `done`.
  - `cmd_len`=0 goes straight from SIM to `done`.
  - At each byte boundary in WDAT: if `wr_valid`=0, `tck_en` drops to 0 and all state holds (stall).
  - When `wr_valid`=1 the byte loads, `wr_ready` pulses for that cycle, and shifting resumes in the same cycle.
- **Read frame:** SYNC, CMD, LEN = {3'b0, `cmd_len`}, SKIP = 0x00, PAD, then RLEN.
  - RLEN samples 16 `tdo` bits into the length word; bits [15:13] are ignored.
  - The last RLEN bit registers `rd_count`.
  - If `rd_count`=0: `done`.
  - If `rd_count` > `cmd_len`: `done` with `err`=1 and no RDAT.
  - Otherwise RDAT samples `rd_count`×8 bits. `rd_valid` pulses the cycle after each 8th bit, with the assembled byte on `rd_data`.
  - `done` is asserted the cycle after the last `rd_valid`.
  - In RLEN/RDAT/VDAT, `tck_en`=1 every cycle, `tdi`=0 and `sel`=1.
- **Version frame:** SYNC, CMD, SKIP = 0x00, PAD, RLEN, then VDAT (32 bits regardless of `rd_count`).
  - `ver_data` updates at the end of VDAT, then `done`.
  - `rd_count`≠4 gives `err`=1, but VDAT is still executed.
- **Reset frame:** SYNC, CMD, then RGAP for RST_GAP cycles with `tck_en`=1, `sel`=0, `tdi`=0, then `done`.
- **Frame timing:** `busy` = !IDLE. `done` and `cmd_ready` never both high in the same cycle; `cmd_ready` rises the cycle after `done`.
- **Counters:** The bit counter is 3 bits inside a byte. Byte counters are 13 bits. No wrap occurs because lengths are bounded by 13 bits.

Test Plan:
- Write, `cmd_len`=2, simcycle=0x0001, bytes 0xA5 and 0x3C -> `tdi` bitstream equals D7,00,02,00,01,00,A5,3C LSB first over 64 `tck_en` cycles; two `wr_ready` pulses; `done`, `err`=0.
- Same write with `wr_valid` withheld 5 cycles before byte 2 -> `tck_en`=0 for exactly 5 cycles; bitstream unchanged.
- Read, `cmd_len`=4; target returns length 3 then 0x11,0x22,0x33 -> `rd_count`=3; three `rd_valid` pulses with matching `rd_data`; `done`, `err`=0.
- Read, `cmd_len`=2; target returns length 5 -> `done` with `err`=1, no `rd_valid`. A read with returned length 0 -> `done` right after RLEN.
- Version against a target returning length 4 and 0x0002ECEC -> `ver_data`=0x0002ECEC, `err`=0. Reset frame -> `sel`=0 for exactly 128 cycles, then `done`.
- `sys_rst` asserted mid-WDAT -> next cycle IDLE, `tck_en`=0, `cmd_ready`=1, no `done`; a following write completes normally.

Source files
------------

// File: rtl/jtag_mac_host.sv
`timescale 1ns/1ps
// jtag_mac_host: host-side initiator for the chif JTAG framing protocol.
// Serializes write/read/version/reset frames LSB first on tdi/sel and gathers tdo readback.
module jtag_mac_host #(
   parameter logic [7:0] SYNC_BYTE = 8'hD7,
   parameter int         RST_GAP   = 128,
   parameter int         RD_OFS    = 0
) (
   input  logic        chif_clk,
   input  logic        sys_rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [12:0] cmd_len,
   input  logic [15:0] cmd_simcycle,
   input  logic [7:0]  wr_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic [31:0] ver_data,
   output logic [12:0] rd_count,
   output logic        done,
   output logic        err,
   output logic        busy,
   output logic        tck_en,
   output logic        tdi,
   output logic        sel,
   input  logic        tdo
);

   localparam int AUX_MAX = (RST_GAP > RD_OFS) ? RST_GAP : RD_OFS;
   localparam int AW      = $clog2(AUX_MAX + 1);
   localparam logic [AW-1:0] GAP_LAST = AW'(RST_GAP - 1);
   localparam logic [AW-1:0] PAD_LAST = AW'((RD_OFS > 0) ? RD_OFS - 1 : 0);
   localparam logic [AW-1:0] AUX_ONE  = AW'(1);

   typedef enum logic [3:0] {
      S_IDLE, S_SYNC, S_CMD, S_LEN, S_SIM, S_WDAT, S_SKIP,
      S_PAD, S_RLEN, S_RDAT, S_RTAIL, S_VDAT, S_RGAP, S_FIN
   } state_t;

   state_t         state, state_next;
   logic [1:0]     op_q;
   logic [12:0]    len_q;
   logic [15:0]    sim_q;
   logic [4:0]     bit_idx;
   logic [12:0]    byte_cnt;
   logic [AW-1:0]  aux_cnt;
   logic [7:0]     wr_sr;
   logic [30:0]    rx_sr;
   logic [31:0]    rx_next;
   logic           err_q;
   logic           field_last;
   logic [2:0]     op_code;
   logic [7:0]     cmd_byte;
   logic [15:0]    len_word;
   logic [12:0]    rlen;
   logic           sample;

   always_comb begin
      case (op_q)
         2'b00:   op_code = 3'd0;
         2'b01:   op_code = 3'd1;
         2'b10:   op_code = 3'd5;
         default: op_code = 3'd7;
      endcase
   end

   // Incoming bits enter at the top, so after N samples the first bit sits at 32-N.
   assign cmd_byte  = {5'b0, op_code};
   assign len_word  = {3'b0, len_q};
   assign rx_next   = {tdo, rx_sr};
   assign rlen      = rx_next[28:16];
   assign sample    = tck_en && (state == S_RLEN || state == S_RDAT || state == S_VDAT);
   assign sel       = tck_en && (state != S_RGAP);
   assign done      = (state == S_FIN);
   assign err       = done && err_q;
   assign busy      = (state != S_IDLE);
   assign cmd_ready = (state == S_IDLE);

   always_ff @(posedge chif_clk) begin
      if (sys_rst) state <= S_IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      tck_en     = 1'b0;
      tdi        = 1'b0;
      field_last = 1'b0;
      wr_ready   = 1'b0;
      case (state)
         S_IDLE: if (cmd_valid) state_next = S_SYNC;
         S_SYNC: begin
            tck_en = 1'b1;
            tdi    = SYNC_BYTE[bit_idx[2:0]];
            if (bit_idx == 5'd7) begin
               field_last = 1'b1;
               state_next = S_CMD;
            end
         end
         S_CMD: begin
            tck_en = 1'b1;
            tdi    = cmd_byte[bit_idx[2:0]];
            if (bit_idx == 5'd7) begin
               field_last = 1'b1;
               case (op_q)
                  2'b00, 2'b01: state_next = S_LEN;
                  2'b10:        state_next = S_SKIP;
                  default:      state_next = S_RGAP;
               endcase
            end
         end
         S_LEN: begin
            tck_en = 1'b1;
            tdi    = len_word[bit_idx[3:0]];
            if (bit_idx == 5'd15) begin
               field_last = 1'b1;
               state_next = (op_q == 2'b00) ? S_SIM : S_SKIP;
            end
         end
         S_SIM: begin
            tck_en = 1'b1;
            tdi    = sim_q[bit_idx[3:0]];
            if (bit_idx == 5'd15) begin
               field_last = 1'b1;
               state_next = (len_q == 13'd0) ? S_FIN : S_WDAT;
            end
         end
         // A missing byte at a boundary freezes the bit strobe and every counter.
         S_WDAT: begin
            if (bit_idx[2:0] == 3'd0) begin
               tck_en   = wr_valid;
               wr_ready = wr_valid;
               tdi      = wr_data[0];
            end else begin
               tck_en = 1'b1;
               tdi    = wr_sr[bit_idx[2:0]];
            end
            if (bit_idx[2:0] == 3'd7) begin
               field_last = 1'b1;
               if (byte_cnt + 13'd1 == len_q) state_next = S_FIN;
            end
         end
         S_SKIP: begin
            tck_en = 1'b1;
            if (bit_idx == 5'd7) begin
               field_last = 1'b1;
               state_next = (RD_OFS > 0) ? S_PAD : S_RLEN;
            end
         end
         S_PAD: begin
            tck_en = 1'b1;
            if (aux_cnt == PAD_LAST) begin
               field_last = 1'b1;
               state_next = S_RLEN;
            end
         end
         S_RLEN: begin
            tck_en = 1'b1;
            if (bit_idx == 5'd15) begin
               field_last = 1'b1;
               if (op_q == 2'b10)                        state_next = S_VDAT;
               else if (rlen == 13'd0 || rlen > len_q)   state_next = S_FIN;
               else                                      state_next = S_RDAT;
            end
         end
         S_RDAT: begin
            tck_en = 1'b1;
            if (bit_idx[2:0] == 3'd7) begin
               field_last = 1'b1;
               if (byte_cnt + 13'd1 == rd_count) state_next = S_RTAIL;
            end
         end
         S_RTAIL: state_next = S_FIN;
         S_VDAT: begin
            tck_en = 1'b1;
            if (bit_idx == 5'd31) begin
               field_last = 1'b1;
               state_next = S_FIN;
            end
         end
         S_RGAP: begin
            tck_en = 1'b1;
            if (aux_cnt == GAP_LAST) begin
               field_last = 1'b1;
               state_next = S_FIN;
            end
         end
         S_FIN:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge chif_clk) begin
      if (sys_rst) begin
         op_q     <= 2'b0;
         len_q    <= 13'd0;
         sim_q    <= 16'd0;
         bit_idx  <= 5'd0;
         byte_cnt <= 13'd0;
         aux_cnt  <= '0;
         wr_sr    <= 8'd0;
         rx_sr    <= 31'd0;
         err_q    <= 1'b0;
         rd_data  <= 8'd0;
         rd_valid <= 1'b0;
         ver_data <= 32'd0;
         rd_count <= 13'd0;
      end else begin
         rd_valid <= 1'b0;
         if (state == S_IDLE && cmd_valid) begin
            op_q     <= cmd_op;
            len_q    <= cmd_len;
            sim_q    <= cmd_simcycle;
            bit_idx  <= 5'd0;
            byte_cnt <= 13'd0;
            aux_cnt  <= '0;
            err_q    <= 1'b0;
         end
         if (tck_en) begin
            bit_idx <= field_last ? 5'd0 : bit_idx + 5'd1;
            if (state == S_PAD || state == S_RGAP)
               aux_cnt <= field_last ? '0 : aux_cnt + AUX_ONE;
            if ((state == S_WDAT || state == S_RDAT) && field_last)
               byte_cnt <= byte_cnt + 13'd1;
         end
         if (wr_ready) wr_sr <= wr_data;
         if (sample)   rx_sr <= rx_next[31:1];
         // Version frames flag a length other than 4 but still shift the full word.
         if (state == S_RLEN && field_last) begin
            rd_count <= rlen;
            err_q    <= (op_q == 2'b10) ? (rlen != 13'd4) : (rlen > len_q);
         end
         if (state == S_RDAT && field_last) begin
            rd_valid <= 1'b1;
            rd_data  <= rx_next[31:24];
         end
         if (state == S_VDAT && field_last) ver_data <= rx_next;
      end
   end

endmodule

// File: tb/tb_jtag_mac_host.sv
`timescale 1ns/1ps
// tb_jtag_mac_host: scoreboard bench for jtag_mac_host with a simple tdo target model.
// Expected tdi bytes, readback bytes and frame results are queued and checked by a monitor.
module tb_jtag_mac_host;

   logic        chif_clk = 1'b0;
   logic        sys_rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [12:0] cmd_len;
   logic [15:0] cmd_simcycle;
   logic [7:0]  wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic [31:0] ver_data;
   logic [12:0] rd_count;
   logic        done;
   logic        err;
   logic        busy;
   logic        tck_en;
   logic        tdi;
   logic        sel;
   logic        tdo;

   typedef struct packed {
      logic        err;
      logic [12:0] cnt;
      logic [31:0] ver;
   } done_exp_t;

   logic [7:0] exp_tx[$];
   logic [7:0] exp_rd[$];
   done_exp_t  exp_done[$];

   int checks = 0;
   int fails  = 0;
   int bits_seen = 0, gap_seen = 0, stall_seen = 0, wr_seen = 0, rd_seen = 0, done_seen = 0;
   int s_bits, s_gap, s_stall, s_wr, s_rd, s_done;

   logic [7:0] mon_acc;
   int         mon_nb;

   logic [7:0] resp_mem [0:7];
   int         resp_n;
   int         resp_start;
   int         t_cnt;
   int         t_idx;

   jtag_mac_host dut (
      .chif_clk     (chif_clk),
      .sys_rst      (sys_rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_len      (cmd_len),
      .cmd_simcycle (cmd_simcycle),
      .wr_data      (wr_data),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .ver_data     (ver_data),
      .rd_count     (rd_count),
      .done         (done),
      .err          (err),
      .busy         (busy),
      .tck_en       (tck_en),
      .tdi          (tdi),
      .sel          (sel),
      .tdo          (tdo)
   );

   always #5 chif_clk = ~chif_clk;

   // Target model: counts selected bits of the frame and replays a canned response.
   always @(posedge chif_clk) begin
      if (sys_rst || done)   t_cnt <= 0;
      else if (tck_en && sel) t_cnt <= t_cnt + 1;
   end

   assign t_idx = t_cnt - resp_start;

   always_comb begin
      tdo = 1'b0;
      if (t_cnt >= resp_start && t_idx < resp_n * 8)
         tdo = resp_mem[t_idx[5:3]][t_idx[2:0]];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic noteUnexpected(input string name, input logic [31:0] act);
      checks++;
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected nothing", name, act);
   endtask

   task automatic tick();
      @(posedge chif_clk);
      #1;
   endtask

   task automatic pushTx(input logic [7:0] b);
      exp_tx.push_back(b);
   endtask

   task automatic pushZeros(input int n);
      for (int i = 0; i < n; i++) exp_tx.push_back(8'h00);
   endtask

   task automatic snap();
      s_bits  = bits_seen;
      s_gap   = gap_seen;
      s_stall = stall_seen;
      s_wr    = wr_seen;
      s_rd    = rd_seen;
      s_done  = done_seen;
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [12:0] len, input logic [15:0] sim);
      bit got;
      got          = 1'b0;
      cmd_op       = op;
      cmd_len      = len;
      cmd_simcycle = sim;
      cmd_valid    = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge chif_clk);
         if (cmd_ready) begin
            got = 1'b1;
            break;
         end
      end
      tick();
      cmd_valid = 1'b0;
      if (!got) noteUnexpected("cmd_ready_timeout", 32'(cmd_ready));
   endtask

   task automatic waitDone(input string name, input int exp_lat);
      int n;
      n = 0;
      for (int c = 1; c <= 3000; c++) begin
         @(negedge chif_clk);
         if (done) begin
            n = c;
            break;
         end
      end
      if (n == 0) noteUnexpected({name, "_done_timeout"}, 32'(busy));
      else        checkOutput({name, "_latency"}, 32'(n), 32'(exp_lat));
      tick();
   endtask

   task automatic offerByte(input logic [7:0] b);
      bit got;
      got      = 1'b0;
      wr_data  = b;
      wr_valid = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(negedge chif_clk);
         if (wr_ready) begin
            got = 1'b1;
            break;
         end
      end
      tick();
      wr_valid = 1'b0;
      if (!got) noteUnexpected("wr_ready_timeout", 32'(wr_ready));
   endtask

   task automatic feedBytes(input logic [7:0] b0, input logic [7:0] b1, input int gap);
      offerByte(b0);
      repeat (7 + gap) tick();
      offerByte(b1);
   endtask

   task automatic checkLeft(input string name);
      checkOutput({name, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
      checkOutput({name, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
      checkOutput({name, "_done_left"}, 32'(exp_done.size()), 32'd0);
   endtask

   task automatic queueWrite();
      pushTx(8'hD7); pushTx(8'h00); pushTx(8'h02); pushTx(8'h00);
      pushTx(8'h01); pushTx(8'h00); pushTx(8'hA5); pushTx(8'h3C);
   endtask

   // Monitor: pops the scoreboard whenever the DUT shows a bit, a byte or a frame end.
   initial begin
      done_exp_t d;
      logic [7:0] e;
      mon_nb = 0;
      mon_acc = 8'h00;
      forever begin
         @(negedge chif_clk);
         if (sys_rst) begin
            mon_nb = 0;
            exp_tx.delete();
            exp_rd.delete();
            exp_done.delete();
         end else begin
            if (tck_en && sel) begin
               bits_seen++;
               mon_acc = {tdi, mon_acc[7:1]};
               mon_nb++;
               if (mon_nb == 8) begin
                  mon_nb = 0;
                  if (exp_tx.size() == 0) noteUnexpected("tdi_extra_byte", 32'(mon_acc));
                  else begin
                     e = exp_tx.pop_front();
                     checkOutput("tdi_byte", 32'(mon_acc), 32'(e));
                  end
               end
            end
            if (tck_en && !sel)           gap_seen++;
            if (busy && !tck_en && !done) stall_seen++;
            if (wr_ready)                 wr_seen++;
            if (rd_valid) begin
               rd_seen++;
               if (exp_rd.size() == 0) noteUnexpected("rd_extra_byte", 32'(rd_data));
               else begin
                  e = exp_rd.pop_front();
                  checkOutput("rd_data", 32'(rd_data), 32'(e));
               end
            end
            if (done) begin
               done_seen++;
               checkOutput("done_with_cmd_ready", 32'(cmd_ready), 32'd0);
               if (exp_done.size() == 0) noteUnexpected("done_unexpected", 32'(err));
               else begin
                  d = exp_done.pop_front();
                  checkOutput("err", 32'(err), 32'(d.err));
                  checkOutput("rd_count", 32'(rd_count), 32'(d.cnt));
                  checkOutput("ver_data", ver_data, d.ver);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      sys_rst      = 1'b1;
      cmd_valid    = 1'b0;
      cmd_op       = 2'b00;
      cmd_len      = 13'd0;
      cmd_simcycle = 16'd0;
      wr_data      = 8'h00;
      wr_valid     = 1'b0;
      resp_n       = 0;
      resp_start   = 0;
      for (int i = 0; i < 8; i++) resp_mem[i] = 8'h00;
      repeat (3) tick();
      sys_rst = 1'b0;

      @(negedge chif_clk);
      $display("[TB] reset state");
      checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_tck_en", 32'(tck_en), 32'd0);
      checkOutput("rst_sel", 32'(sel), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("rst_rd_count", 32'(rd_count), 32'd0);
      checkOutput("rst_ver_data", ver_data, 32'd0);
      tick();

      $display("[TB] write, no stall");
      queueWrite();
      exp_done.push_back('{err: 1'b0, cnt: 13'd0, ver: 32'd0});
      snap();
      applyStimulus(2'b00, 13'd2, 16'h0001);
      fork
         feedBytes(8'hA5, 8'h3C, 0);
         waitDone("wr1", 65);
      join
      checkOutput("wr1_bits", 32'(bits_seen - s_bits), 32'd64);
      checkOutput("wr1_wr_ready", 32'(wr_seen - s_wr), 32'd2);
      checkOutput("wr1_stall", 32'(stall_seen - s_stall), 32'd0);
      checkLeft("wr1");

      $display("[TB] write, 5-cycle stall before byte 2");
      queueWrite();
      exp_done.push_back('{err: 1'b0, cnt: 13'd0, ver: 32'd0});
      snap();
      applyStimulus(2'b00, 13'd2, 16'h0001);
      fork
         feedBytes(8'hA5, 8'h3C, 5);
         waitDone("wr2", 70);
      join
      checkOutput("wr2_bits", 32'(bits_seen - s_bits), 32'd64);
      checkOutput("wr2_wr_ready", 32'(wr_seen - s_wr), 32'd2);
      checkOutput("wr2_stall", 32'(stall_seen - s_stall), 32'd5);
      checkLeft("wr2");

      $display("[TB] read, len 4, target returns 3 bytes");
      resp_mem[0] = 8'h03; resp_mem[1] = 8'h00; resp_mem[2] = 8'h11;
      resp_mem[3] = 8'h22; resp_mem[4] = 8'h33;
      resp_n = 5; resp_start = 40;
      pushTx(8'hD7); pushTx(8'h01); pushTx(8'h04); pushTx(8'h00); pushZeros(6);
      exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h33);
      exp_done.push_back('{err: 1'b0, cnt: 13'd3, ver: 32'd0});
      snap();
      applyStimulus(2'b01, 13'd4, 16'h0000);
      waitDone("rd1", 82);
      checkOutput("rd1_bits", 32'(bits_seen - s_bits), 32'd80);
      checkOutput("rd1_rd_valid", 32'(rd_seen - s_rd), 32'd3);
      checkLeft("rd1");

      $display("[TB] read, len 2, target returns length 5");
      resp_mem[0] = 8'h05; resp_mem[1] = 8'h00;
      resp_n = 2; resp_start = 40;
      pushTx(8'hD7); pushTx(8'h01); pushTx(8'h02); pushTx(8'h00); pushZeros(3);
      exp_done.push_back('{err: 1'b1, cnt: 13'd5, ver: 32'd0});
      snap();
      applyStimulus(2'b01, 13'd2, 16'h0000);
      waitDone("rd2", 57);
      checkOutput("rd2_rd_valid", 32'(rd_seen - s_rd), 32'd0);
      checkLeft("rd2");

      $display("[TB] read, target returns length 0");
      resp_mem[0] = 8'h00; resp_mem[1] = 8'h00;
      resp_n = 2; resp_start = 40;
      pushTx(8'hD7); pushTx(8'h01); pushTx(8'h02); pushTx(8'h00); pushZeros(3);
      exp_done.push_back('{err: 1'b0, cnt: 13'd0, ver: 32'd0});
      snap();
      applyStimulus(2'b01, 13'd2, 16'h0000);
      waitDone("rd3", 57);
      checkOutput("rd3_rd_valid", 32'(rd_seen - s_rd), 32'd0);
      checkLeft("rd3");

      $display("[TB] version");
      resp_mem[0] = 8'h04; resp_mem[1] = 8'h00; resp_mem[2] = 8'hEC;
      resp_mem[3] = 8'hEC; resp_mem[4] = 8'h02; resp_mem[5] = 8'h00;
      resp_n = 6; resp_start = 24;
      pushTx(8'hD7); pushTx(8'h05); pushZeros(7);
      exp_done.push_back('{err: 1'b0, cnt: 13'd4, ver: 32'h0002ECEC});
      snap();
      applyStimulus(2'b10, 13'd0, 16'h0000);
      waitDone("ver", 73);
      checkOutput("ver_bits", 32'(bits_seen - s_bits), 32'd72);
      checkLeft("ver");

      $display("[TB] reset frame");
      resp_n = 0;
      pushTx(8'hD7); pushTx(8'h07);
      exp_done.push_back('{err: 1'b0, cnt: 13'd4, ver: 32'h0002ECEC});
      snap();
      applyStimulus(2'b11, 13'd0, 16'h0000);
      waitDone("rst", 145);
      checkOutput("rst_gap_cycles", 32'(gap_seen - s_gap), 32'd128);
      checkOutput("rst_bits", 32'(bits_seen - s_bits), 32'd16);
      checkLeft("rst");

      $display("[TB] sys_rst in the middle of write data");
      queueWrite();
      snap();
      wr_data  = 8'hA5;
      wr_valid = 1'b1;
      applyStimulus(2'b00, 13'd2, 16'h0001);
      repeat (49) tick();
      wr_valid = 1'b0;
      repeat (3) tick();
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      @(negedge chif_clk);
      checkOutput("abort_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_tck_en", 32'(tck_en), 32'd0);
      checkOutput("abort_rd_count", 32'(rd_count), 32'd0);
      checkOutput("abort_ver_data", ver_data, 32'd0);
      checkOutput("abort_wr_ready", 32'(wr_seen - s_wr), 32'd1);
      repeat (10) @(negedge chif_clk);
      checkOutput("abort_no_done", 32'(done_seen - s_done), 32'd0);
      tick();

      $display("[TB] write after abort");
      queueWrite();
      exp_done.push_back('{err: 1'b0, cnt: 13'd0, ver: 32'd0});
      snap();
      applyStimulus(2'b00, 13'd2, 16'h0001);
      fork
         feedBytes(8'hA5, 8'h3C, 0);
         waitDone("wr3", 65);
      join
      checkOutput("wr3_bits", 32'(bits_seen - s_bits), 32'd64);
      checkLeft("wr3");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
